// File: rtl/mem_explorer_if.sv
// Board-side bundle of mem_explorer: raw buttons and switches in, addresses and read data out.
interface mem_explorer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic              inc_w;
   logic              dec_w;
   logic              inc_r;
   logic              dec_r;
   logic              wr_btn;
   logic              clr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output inc_w, dec_w, inc_r, dec_r, wr_btn, clr, wdata,
      input  waddr, raddr, rdata, rvalid
   );

   modport slave (
      input  inc_w, dec_w, inc_r, dec_r, wr_btn, clr, wdata,
      output waddr, raddr, rdata, rvalid
   );
endinterface

// File: rtl/mem_explorer.sv
// Button-driven memory explorer: write/read address counters with auto-repeat,
// wrap or saturate ends, and a simple dual-port RAM with a registered read port.
module mem_explorer #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 10,
   parameter int WRAP        = 1,
   parameter int AUTO_INC    = 0,
   parameter int REPEAT_DLY  = 50000000,
   parameter int REPEAT_RATE = 10000000
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_explorer_if.slave bus
);
   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  DLY_C    = CNT_W'(REPEAT_DLY);
   localparam logic [CNT_W-1:0]  RATE_C   = CNT_W'(REPEAT_RATE);
   localparam int B_INC_W = 0, B_DEC_W = 1, B_INC_R = 2, B_DEC_R = 3, B_WR = 4, B_CLR = 5;

   logic [5:0]        raw_s, sync1_r, sync2_r, prev_r, press_s;
   logic [3:0]        rep_hit_s, step_s;
   logic [ADDR_W-1:0] waddr_r, raddr_r, waddr_nxt_s, raddr_nxt_s;
   logic [DATA_W-1:0] mem_r [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_r;
   logic              we_s, w_inc_s, ev_s, req_r, rvalid_r, init_r;

   function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                   input logic up, input logic dn);
      logic [ADDR_W-1:0] r;
      r = a;
      if (up && !dn) begin
         if (a == ADDR_MAX) r = (WRAP != 0) ? '0 : ADDR_MAX;
         else               r = a + ADDR_W'(1);
      end else if (dn && !up) begin
         if (a == '0) r = (WRAP != 0) ? ADDR_MAX : '0;
         else         r = a - ADDR_W'(1);
      end else begin
         r = a;
      end
      return r;
   endfunction

   assign raw_s = {bus.clr, bus.wr_btn, bus.dec_r, bus.inc_r, bus.dec_w, bus.inc_w};

   // Two-flop synchronizers followed by a rising-edge detector per button
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 6'b0;
         sync2_r <= 6'b0;
         prev_r  <= 6'b0;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign press_s = sync2_r & ~prev_r;

   // cnt_r counts held cycles since the last step; 0 means the button is idle
   for (genvar b = 0; b < 4; b++) begin : g_rep
      logic [CNT_W-1:0] cnt_r;
      logic             rep_mode_r;
      logic [CNT_W-1:0] thr_s;

      assign thr_s        = rep_mode_r ? RATE_C : DLY_C;
      assign rep_hit_s[b] = sync2_r[b] && !press_s[b] && (cnt_r == thr_s);
      assign step_s[b]    = press_s[b] || rep_hit_s[b];

      // Hold timer: initial delay, then periodic repeat while held
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_r      <= '0;
            rep_mode_r <= 1'b0;
         end else if (!sync2_r[b]) begin
            cnt_r      <= '0;
            rep_mode_r <= 1'b0;
         end else if (press_s[b] || press_s[B_CLR]) begin
            cnt_r      <= CNT_W'(1);
            rep_mode_r <= 1'b0;
         end else if (rep_hit_s[b]) begin
            cnt_r      <= CNT_W'(1);
            rep_mode_r <= 1'b1;
         end else if (cnt_r != '0) begin
            cnt_r      <= cnt_r + CNT_W'(1);
         end
      end
   end

   // A clear press swallows the write issued in the same cycle
   assign we_s    = press_s[B_WR] && !press_s[B_CLR];
   assign w_inc_s = step_s[B_INC_W] || ((AUTO_INC != 0) && we_s);

   // Next addresses and read-event detection
   always_comb begin
      waddr_nxt_s = waddr_r;
      raddr_nxt_s = raddr_r;
      ev_s        = init_r;
      if (press_s[B_CLR]) begin
         waddr_nxt_s = '0;
         raddr_nxt_s = '0;
         ev_s        = 1'b1;
      end else begin
         waddr_nxt_s = step_addr(waddr_r, w_inc_s, step_s[B_DEC_W]);
         raddr_nxt_s = step_addr(raddr_r, step_s[B_INC_R], step_s[B_DEC_R]);
         ev_s        = init_r || we_s || (raddr_nxt_s != raddr_r);
      end
   end

   // Address counters and the two-stage read pipeline (request, then data)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr_r  <= '0;
         raddr_r  <= '0;
         init_r   <= 1'b1;
         req_r    <= 1'b0;
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
      end else begin
         waddr_r  <= waddr_nxt_s;
         raddr_r  <= raddr_nxt_s;
         init_r   <= 1'b0;
         req_r    <= ev_s;
         rvalid_r <= req_r;
         if (req_r) rdata_r <= mem_r[raddr_r];
      end
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_s) mem_r[waddr_r] <= bus.wdata;
   end

   assign bus.waddr  = waddr_r;
   assign bus.raddr  = raddr_r;
   assign bus.rdata  = rdata_r;
   assign bus.rvalid = rvalid_r;
endmodule

// File: doc/mem_explorer.md
Name: mem_explorer

Overview:
- Parametrised dual-port memory explorer, successor to the fixed 1024x16 switch/LED memory exercise.
- Holds a write-address counter and a read-address counter, each driven by inc/dec buttons. Adds hold-to-auto-repeat, a wrap or saturate mode, non-power-of-2 depth, and an optional write auto-increment.
- Writes `wdata` on a write-button press and presents `rdata` with a `rvalid` strobe.
- Sits between the board's switches/buttons and the LED/seven-segment display logic.

Parameters:
- DATA_W, 16, memory word width.
- DEPTH, 1024, number of words; any value from 2 to 65536.
- ADDR_W, 10, address width; must equal clog2(DEPTH).
- WRAP, 1, 1 = addresses wrap at the ends, 0 = addresses saturate.
- AUTO_INC, 0, 1 = `waddr` steps +1 after every write.
- REPEAT_DLY, 50000000, cycles a button must be held before auto-repeat starts.
- REPEAT_RATE, 10000000, cycles between auto-repeat steps once repeating.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- inc_w  in  1  raw button, increment `waddr`; asynchronous to `clk`.
- dec_w  in  1  raw button, decrement `waddr`.
- inc_r  in  1  raw button, increment `raddr`.
- dec_r  in  1  raw button, decrement `raddr`.
- wr_btn  in  1  raw button, write `wdata` to `waddr`.
- clr  in  1  raw button, clear both addresses to 0.
- wdata  in  DATA_W  write data (switches); sampled in the write cycle.
- waddr  out  ADDR_W  current write address.
- raddr  out  ADDR_W  current read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse when `rdata` has been refreshed.

Behaviour:
- Reset state:
  - `reset_n` low asynchronously clears `waddr`, `raddr`, `rdata` and `rvalid` to 0, plus all synchronizers, edge registers and repeat counters.
  - RAM contents are not reset.
- Input conditioning:
  - Each of the 6 raw buttons passes through a 2-flop synchronizer, then an edge detector.
  - A "press" is a one-cycle pulse on a synchronized 0->1 transition. No debounce.
- Auto-repeat (`inc_w`, `dec_w`, `inc_r`, `dec_r` only):
  - A press yields one step.
  - If the button is still held REPEAT_DLY cycles after its press, one step is generated, then one more every REPEAT_RATE cycles while held.
  - Release clears that button's repeat counter immediately.
  - `wr_btn` and `clr` never repeat.
- Per-cycle priority for each address counter: `clr` > steps.
  - A `clr` press sets both addresses to 0 next cycle, discards same-cycle steps and writes, and restarts all repeat counters.
- Step arithmetic:
  - Net step = (inc ? +1 : 0) + (dec ? -1 : 0). An AUTO_INC write counts as an inc on `waddr`.
  - Inc and dec in the same cycle cancel; the address is unchanged.
  - Boundary with WRAP=1: DEPTH-1 +1 -> 0, and 0 -1 -> DEPTH-1.
  - Boundary with WRAP=0: the address holds at DEPTH-1 or at 0. A held step still occurs, with no change.
  - The address is never >= DEPTH.
- Write:
  - A `wr_btn` press in cycle t writes `wdata` to `waddr` as registered at t; this is the pre-step address.
  - A `waddr` step in the same cycle takes effect at t+1.
- Read events:
  - A read event is any `raddr` step that changes the address, any write commit, any `clr`, or the first cycle after `reset_n` deasserts.
  - For an event at cycle t, the read request fires at t+1 using the updated `raddr`. `rdata` is loaded and `rvalid` pulses at t+2.
  - A write at t to the address being read is visible in `rdata` at t+2 (no read-during-write hazard).
  - Back-to-back events each produce their own `rvalid`. `rdata` holds between events.
- Saturated steps (no address change) and `waddr`-only steps produce no read event.
- Reset mid-operation aborts any pending read; no `rvalid` pulse is issued for it.
- RAM is an inferred simple dual-port block RAM: one write port, one registered read port, same clock.

Test Plan:
- After reset release, press `wr_btn` with `wdata`=16'hA5A5 at `waddr`=0 -> RAM[0]=A5A5. `rvalid` pulses, and `rdata`=A5A5 two cycles after the write commit (`raddr`=0).
- Tap `inc_r` 3 times -> `raddr`=3. Each tap yields one `rvalid`, with `rdata`=RAM[3] after the last tap. Simultaneous `inc_r`+`dec_r` press -> `raddr` unchanged, no `rvalid`.
- DEPTH=10, WRAP=1: `dec_r` at 0 -> `raddr`=9; `inc_r` at 9 -> 0. WRAP=0: `dec_r` at 0 stays 0 with no `rvalid`; `inc_r` at 9 stays 9.
- REPEAT_DLY=20, REPEAT_RATE=5: hold `inc_w` for 40 cycles after the synchronized press -> `waddr` steps at press, +20, +25, +30, +35 (5 total). Release then re-press -> a single step.
- AUTO_INC=1: 4 `wr_btn` presses with `wdata` 1,2,3,4 -> RAM[0..3]=1..4 and `waddr`=4. A `wr_btn` plus `dec_w` press in the same cycle -> write at the old address, `waddr` unchanged.
- `clr` press with `waddr`=7, `raddr`=5, and `inc_r` in the same cycle -> both addresses 0 and `rdata`=RAM[0] at +2. Assert `reset_n` low between a read event and its `rvalid` -> no `rvalid`, all outputs 0.
